// File: rtl/riscvsys_memcpy_init.sv
// Word-granular memory-to-memory copy engine; initiator on the picorv32 native
// memory bus. Alternates one read and one write per word, with a stall timeout.
module riscvsys_memcpy_init #(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [31:0]      i_src,
    input  logic [31:0]      i_dst,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [LEN_W-1:0] o_words,
    output logic             o_mem_valid,
    output logic             o_mem_instr,
    input  logic             i_mem_ready,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_wdata,
    output logic [3:0]       o_mem_wstrb,
    input  logic [31:0]      i_mem_rdata
);
    // Wait counter only needs to reach TIMEOUT_CYCLES-1; the abort fires on that edge.
    localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit            TO_EN   = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_FINISH} state_t;

    state_t            r_state, w_state_nxt;
    logic [31:0]       r_src, w_src_nxt;
    logic [31:0]       r_dst, w_dst_nxt;
    logic [LEN_W-1:0]  r_rem, w_rem_nxt;
    logic [LEN_W-1:0]  r_words, w_words_nxt;
    logic [31:0]       r_data, w_data_nxt;
    logic [TW-1:0]     r_wait, w_wait_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic              r_valid, w_valid_nxt;
    logic [31:0]       r_addr, w_addr_nxt;
    logic [3:0]        r_wstrb, w_wstrb_nxt;
    logic              w_xfer;
    logic              w_tmo;

    assign w_xfer = r_valid && i_mem_ready;
    assign w_tmo  = TO_EN && r_valid && !i_mem_ready && (r_wait == TO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_rem_nxt   = r_rem;
        w_words_nxt = r_words;
        w_data_nxt  = r_data;
        w_wait_nxt  = r_wait;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_valid_nxt = r_valid;
        w_addr_nxt  = r_addr;
        w_wstrb_nxt = r_wstrb;

        // Stall bookkeeping; a completing transfer below overrides this path.
        if (r_valid && !i_mem_ready) begin
            if (w_tmo) begin
                w_valid_nxt = 1'b0;
                w_err_nxt   = 1'b1;
                w_state_nxt = S_FINISH;
            end else if (TO_EN) begin
                w_wait_nxt = r_wait + 1'b1;
            end
        end

        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_src_nxt   = i_src;
                    w_dst_nxt   = i_dst;
                    w_rem_nxt   = i_len;
                    w_words_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_wait_nxt  = '0;
                    w_busy_nxt  = 1'b1;
                    if ((i_src[1:0] != 2'b00) || (i_dst[1:0] != 2'b00)) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_FINISH;
                    end else if (i_len == '0) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_state_nxt = S_READ;
                        w_valid_nxt = 1'b1;
                        w_addr_nxt  = i_src;
                        w_wstrb_nxt = 4'h0;
                    end
                end
            end
            S_READ: begin
                if (w_xfer) begin
                    w_data_nxt  = i_mem_rdata;
                    w_src_nxt   = r_src + 32'd4;
                    w_wait_nxt  = '0;
                    w_addr_nxt  = r_dst;
                    w_wstrb_nxt = 4'hF;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_xfer) begin
                    w_dst_nxt   = r_dst + 32'd4;
                    w_words_nxt = r_words + 1'b1;
                    w_rem_nxt   = r_rem - 1'b1;
                    w_wait_nxt  = '0;
                    w_wstrb_nxt = 4'h0;
                    if (r_rem == LEN_W'(1)) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_addr_nxt  = r_src;
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_FINISH: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_valid_nxt = 1'b0;
                w_wstrb_nxt = 4'h0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_words <= '0;
            r_data  <= '0;
            r_wait  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_wstrb <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_rem   <= w_rem_nxt;
            r_words <= w_words_nxt;
            r_data  <= w_data_nxt;
            r_wait  <= w_wait_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_valid <= w_valid_nxt;
            r_addr  <= w_addr_nxt;
            r_wstrb <= w_wstrb_nxt;
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_words     = r_words;
    assign o_mem_valid = r_valid;
    assign o_mem_instr = 1'b0;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_data;
    assign o_mem_wstrb = r_wstrb;

endmodule

// File: doc/riscvsys_memcpy_init.md
Name: riscvsys_memcpy_init

Overview:
- Word-granular memory-to-memory copy engine that acts as an initiator on the picorv32 native memory interface (valid/ready, addr, wdata, wstrb, rdata).
- It is the initiator-side counterpart to the testbench memory responder.
- It is used in riscvsys to generate bus traffic and stalls independently of the core, and to exercise responders (memory, console, tb-control) under back-to-back and stalled handshakes.
- A simple command port starts each copy.

Parameters:
- LEN_W, 16, width of the word-count field; max copy length is 2^LEN_W-1 words.
- TIMEOUT_CYCLES, 1024, consecutive cycles that o_mem_valid may wait on i_mem_ready before the copy aborts; 0 disables the timeout.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  asynchronous active-high reset.
- i_start  input  1  start request; sampled only in IDLE.
- i_src  input  32  source byte address; must be word aligned.
- i_dst  input  32  destination byte address; must be word aligned.
- i_len  input  LEN_W  number of 32-bit words to copy.
- o_busy  output  1  high from the cycle after an accepted start until the done pulse.
- o_done  output  1  one-cycle pulse at completion, abort or error.
- o_err  output  1  sticky error flag; cleared by the next accepted start.
- o_words  output  LEN_W  count of words written so far in the current copy.
- o_mem_valid  output  1  request valid.
- o_mem_instr  output  1  always 0.
- i_mem_ready  input  1  responder ready; may be combinational from o_mem_valid.
- o_mem_addr  output  32  request address.
- o_mem_wdata  output  32  write data.
- o_mem_wstrb  output  4  write strobes; 4'b0000 = read, 4'b1111 = write.
- i_mem_rdata  input  32  read data; valid in the cycle where o_mem_valid && i_mem_ready.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; internal address registers, counters and data registers 0.
- Reset asserted mid-copy drops o_mem_valid immediately (asynchronously). No done pulse is generated. A partially written destination is left as is.
- Handshake rules:
  - A transfer completes on a rising edge where o_mem_valid && i_mem_ready.
  - While o_mem_valid=1 and no transfer has completed, o_mem_addr, o_mem_wdata and o_mem_wstrb are held stable.
  - o_mem_valid is never withdrawn before ready, except on reset or timeout.
  - Outputs are registered. Combinational ready gives one transfer per cycle.
- FSM states: IDLE, READ, WRITE, FINISH.
- IDLE + i_start:
  - Capture src, dst and len. Clear o_err and o_words.
  - If i_src[1:0] != 0 or i_dst[1:0] != 0: set o_err and go to FINISH with no bus traffic.
  - Else if i_len == 0: go to FINISH with no bus traffic.
  - Else: go to READ.
  - i_start outside IDLE is ignored.
- READ: o_mem_valid=1, addr=src, wstrb=0. On transfer: latch i_mem_rdata, src += 4, go to WRITE.
- WRITE: o_mem_valid=1, addr=dst, wdata=latched data, wstrb=4'hF. On transfer: dst += 4, o_words += 1, remaining -= 1. If remaining reaches 0, go to FINISH; else go to READ with no idle cycle.
- FINISH: o_done=1 for exactly one cycle, o_busy=0, then IDLE. Latency with zero-wait ready: start to done = 2*len + 2 cycles.
- Address arithmetic: src and dst are 32-bit and wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000). No bounds checking. Overlapping ranges copy in ascending order, word by word, with no hazard handling.
- Timeout: a wait counter increments each cycle that o_mem_valid=1 && !i_mem_ready, and resets on every transfer.
  - When the counter reaches TIMEOUT_CYCLES (if nonzero): deassert o_mem_valid next cycle, set o_err, go to FINISH.
  - o_words reflects the words completed before the abort.
- Simultaneous events: i_start during FINISH is ignored. A transfer on the same edge the timeout would fire takes precedence (no abort).

Test Plan:
- Preload mem[0x100..0x10C] = 1,2,3,4. Start src=0x100, dst=0x200, len=4, ready tied 1 -> mem[0x200..0x20C] = 1,2,3,4; 8 transfers alternating R/W; done at cycle 10 after start; o_words=4; o_err=0.
- Same copy with ready driven by the xorshift PRNG bit 0 -> identical memory result. The checker confirms addr/wdata/wstrb stay stable while valid && !ready.
- len=0 -> o_done one cycle after busy; no o_mem_valid ever asserted. src=0x102 -> o_err=1, done, zero transfers.
- src=0xFFFFFFF8, len=3 -> read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- TIMEOUT_CYCLES=8, ready held 0 -> valid drops after 8 waiting cycles, o_err=1, o_done pulses, o_words=0.
- Assert i_rst during the 2nd WRITE -> o_mem_valid=0 immediately, no done pulse. A following start with len=1 completes normally.
